// File: rtl/raster_to_bitplane.sv
// Packs per-pixel colour values MSB-first into GPU RAM bit-plane bytes/words.
// Define RASTER_PACK_BITMASK_EN to mask unfilled bits on a partial flush.
module raster_to_bitplane #(
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        mode,
  input  logic              line_start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [15:0]       pix_data,
  input  logic              pix_last,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic [1:0]        wr_be,
  output logic [7:0]        wr_bitmask,
  output logic              line_done
);

  typedef enum logic {IDLE, PACK} state_e;

  state_e            state_q, state_d;
  logic [2:0]        mode_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       acc_q;
  logic [3:0]        cnt_q;
  logic              wr_valid_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [15:0]       wr_data_q;
  logic [1:0]        wr_be_q;
  logic [7:0]        wr_bitmask_q;
  logic              last_q;

  logic              mode_ok;
  logic              pix_fire;
  logic              is_word;
  logic [2:0]        lg_bpp;
  logic [4:0]        bpp;
  logic [3:0]        cnt_inc;
  logic [4:0]        filled;
  logic [3:0]        shamt;
  logic [15:0]       pix_mask;
  logic [15:0]       pix_shifted;
  logic [15:0]       acc_next;
  logic              acc_full;
  logic              emit;
  logic [7:0]        mask_next;

  assign mode_ok  = (mode >= 4'd1) && (mode <= 4'd5);
  assign pix_fire = pix_valid && pix_ready;

  // Byte modes: pixel k of width bpp lands at bits [7-k*bpp -: bpp].
  assign is_word     = (mode_q == 3'd5);
  assign lg_bpp      = mode_q - 3'd1;
  assign bpp         = 5'd1 << lg_bpp;
  assign cnt_inc     = cnt_q + 4'd1;
  assign filled      = {1'b0, cnt_inc} << lg_bpp;
  assign shamt       = 4'(5'd8 - filled);
  assign pix_mask    = is_word ? 16'hFFFF : ((16'h1 << bpp) - 16'h1);
  assign pix_shifted = is_word ? pix_data : ((pix_data & pix_mask) << shamt);
  assign acc_next    = acc_q | pix_shifted;
  assign acc_full    = is_word || (filled == 5'd8);
  assign emit        = pix_fire && (acc_full || pix_last);

`ifdef RASTER_PACK_BITMASK_EN
  assign mask_next = is_word ? 8'hFF : ~(8'hFF >> filled[3:0]);
`else
  assign mask_next = 8'hFF;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (line_start)                 state_d = mode_ok ? PACK : IDLE;
    else if (emit && pix_last)      state_d = IDLE;
  end

  // line_start has priority over a same-cycle pixel handshake.
  always_comb begin
    pix_ready = (state_q == PACK) && !line_start && (!wr_valid_q || wr_ready);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q       <= '0;
      addr_q       <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      wr_valid_q   <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_be_q      <= '0;
      wr_bitmask_q <= '0;
      last_q       <= 1'b0;
    end else begin
      if (wr_valid_q && wr_ready) wr_valid_q <= 1'b0;
      if (line_start) begin
        if (mode_ok) begin
          mode_q <= mode[2:0];
          addr_q <= base_addr;
        end
        acc_q <= '0;
        cnt_q <= '0;
        // A still-pending write belongs to an abandoned line; it completes silently.
        if (state_q == PACK) last_q <= 1'b0;
      end else if (pix_fire) begin
        if (emit) begin
          wr_valid_q   <= 1'b1;
          wr_addr_q    <= addr_q;
          wr_data_q    <= is_word ? acc_next : {8'h00, acc_next[7:0]};
          wr_be_q      <= is_word ? 2'b11 : 2'b01;
          wr_bitmask_q <= mask_next;
          last_q       <= pix_last;
          addr_q       <= addr_q + (is_word ? ADDR_W'(2) : ADDR_W'(1));
          acc_q        <= '0;
          cnt_q        <= '0;
        end else begin
          acc_q <= acc_next;
          cnt_q <= cnt_inc;
        end
      end
    end
  end

  assign wr_valid   = wr_valid_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign wr_be      = wr_be_q;
  assign wr_bitmask = wr_bitmask_q;
  assign line_done  = wr_valid_q && wr_ready && last_q;

endmodule
